// File: rtl/mic_pkg.sv
// Shared definitions for the microprogram sequencer: microinstruction layout,
// FSM states, C-bus destination codes and memory request bits.
package mic_pkg;

    localparam int unsigned UINSTR_W  = 31;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned MBR_W     = 8;

    localparam int unsigned NEXT_LSB  = 22;
    localparam int unsigned NEXT_W    = 9;
    localparam int unsigned JAM_LSB   = 19;
    localparam int unsigned JAM_W     = 3;
    localparam int unsigned ALU_LSB   = 11;
    localparam int unsigned ALU_W     = 8;
    localparam int unsigned CCODE_LSB = 7;
    localparam int unsigned CCODE_W   = 4;
    localparam int unsigned MEM_LSB   = 4;
    localparam int unsigned MEM_W     = 3;
    localparam int unsigned BCODE_LSB = 0;
    localparam int unsigned BCODE_W   = 4;

    // Bit indices inside the jam and mem fields
    localparam int unsigned JAM_JMPC  = 2;
    localparam int unsigned JAM_JAMN  = 1;
    localparam int unsigned JAM_JAMZ  = 0;
    localparam int unsigned MEM_WRITE = 2;
    localparam int unsigned MEM_READ  = 1;
    localparam int unsigned MEM_FETCH = 0;

    localparam logic [CCODE_W-1:0] C_MAR  = 4'd0;
    localparam logic [CCODE_W-1:0] C_MDR  = 4'd1;
    localparam logic [CCODE_W-1:0] C_PC   = 4'd2;
    localparam logic [CCODE_W-1:0] C_SP   = 4'd3;
    localparam logic [CCODE_W-1:0] C_LV   = 4'd4;
    localparam logic [CCODE_W-1:0] C_CPP  = 4'd5;
    localparam logic [CCODE_W-1:0] C_TOS  = 4'd6;
    localparam logic [CCODE_W-1:0] C_OPC  = 4'd7;
    localparam logic [CCODE_W-1:0] C_H    = 4'd8;
    localparam logic [CCODE_W-1:0] C_NONE = 4'd15;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        EXEC     = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic [NEXT_W-1:0]  next_addr;
        logic [JAM_W-1:0]   jam;
        logic [ALU_W-1:0]   alu;
        logic [CCODE_W-1:0] ccode;
        logic [MEM_W-1:0]   mem;
        logic [BCODE_W-1:0] bcode;
    } uinstr_t;

    function automatic uinstr_t decode_uinstr(input logic [UINSTR_W-1:0] w);
        uinstr_t u;
        u.next_addr = w[NEXT_LSB  +: NEXT_W];
        u.jam       = w[JAM_LSB   +: JAM_W];
        u.alu       = w[ALU_LSB   +: ALU_W];
        u.ccode     = w[CCODE_LSB +: CCODE_W];
        u.mem       = w[MEM_LSB   +: MEM_W];
        u.bcode     = w[BCODE_LSB +: BCODE_W];
        return u;
    endfunction

endpackage

// File: rtl/mic_next_addr.sv
// Next-MPC formation: OR-merge of the next-address field with MBR and the
// conditional N/Z jam bits. No arithmetic, so no carry between bit 7 and bit 8.
module mic_next_addr
    import mic_pkg::*;
(
    input  logic [NEXT_W-1:0] next_addr,
    input  logic [JAM_W-1:0]  jam,
    input  logic              n_flag,
    input  logic              z_flag,
    input  logic [MBR_W-1:0]  mbr,
    output logic [ADDR_W-1:0] next_mpc
);

    always_comb begin
        next_mpc[MBR_W-1:0] = next_addr[MBR_W-1:0] | (jam[JAM_JMPC] ? mbr : MBR_W'(0));
        next_mpc[MBR_W]     = next_addr[MBR_W]
                            | (jam[JAM_JAMN] & n_flag)
                            | (jam[JAM_JAMZ] & z_flag);
    end

endmodule

// File: rtl/mic_sequencer.sv
// Microprogram sequencer: reads microinstructions from an external control store,
// drives one cycle of datapath controls and memory pulses, then forms the next MPC.
module mic_sequencer
    import mic_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    output logic [ADDR_W-1:0]   cs_addr,
    input  logic [UINSTR_W-1:0] cs_data,
    input  logic                n_flag,
    input  logic                z_flag,
    input  logic [MBR_W-1:0]    mbr,
    input  logic                mem_ready,
    input  logic                halt,
    output logic [CCODE_W-1:0]  controlC,
    output logic [BCODE_W-1:0]  controlB,
    output logic [ALU_W-1:0]    alu_ctrl,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                mem_fetch,
    output logic                busy,
    output logic                halted
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mpc_q, mpc_d;
    logic [NEXT_W-1:0]   ir_next_q, ir_next_d;
    logic [JAM_W-1:0]    ir_jam_q, ir_jam_d;
    logic [ADDR_W-1:0]   next_mpc;
    logic [CCODE_W-1:0]  controlc_d;
    logic [BCODE_W-1:0]  controlb_d;
    logic [ALU_W-1:0]    alu_ctrl_d;
    logic                mem_rd_d, mem_wr_d, mem_fetch_d;
    logic                busy_d, halted_d;
    logic                mem_req;
    uinstr_t             uin;

    assign uin     = decode_uinstr(cs_data);
    assign cs_addr = mpc_q;
    // Pulses are only ever high in EXEC, so they double as "this uinstr touches memory"
    assign mem_req = mem_rd | mem_wr | mem_fetch;

    mic_next_addr u_next_addr (
        .next_addr (ir_next_q),
        .jam       (ir_jam_q),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .mbr       (mbr),
        .next_mpc  (next_mpc)
    );

    always_comb begin
        state_d     = state_q;
        mpc_d       = mpc_q;
        ir_next_d   = ir_next_q;
        ir_jam_d    = ir_jam_q;
        controlc_d  = C_NONE;
        controlb_d  = '0;
        alu_ctrl_d  = '0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_fetch_d = 1'b0;
        busy_d      = 1'b0;
        halted_d    = 1'b0;

        case (state_q)
            FETCH: begin
                state_d   = EXEC;
                ir_next_d = uin.next_addr;
                ir_jam_d  = uin.jam;
            end
            EXEC: begin
                mpc_d = next_mpc;
                if (mem_req)   state_d = MEM_WAIT;
                else if (halt) state_d = HALTED;
                else           state_d = FETCH;
            end
            MEM_WAIT: begin
                if (mem_ready) state_d = halt ? HALTED : FETCH;
            end
            HALTED: begin
                if (!halt) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        if (state_d == EXEC) begin
            controlc_d  = uin.ccode;
            controlb_d  = uin.bcode;
            alu_ctrl_d  = uin.alu;
            mem_wr_d    = uin.mem[MEM_WRITE];
            mem_rd_d    = uin.mem[MEM_READ];
            mem_fetch_d = uin.mem[MEM_FETCH];
        end
        busy_d   = (state_d == MEM_WAIT);
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            mpc_q     <= '0;
            ir_next_q <= '0;
            ir_jam_q  <= '0;
            controlC  <= C_NONE;
            controlB  <= '0;
            alu_ctrl  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_fetch <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mpc_q     <= mpc_d;
            ir_next_q <= ir_next_d;
            ir_jam_q  <= ir_jam_d;
            controlC  <= controlc_d;
            controlB  <= controlb_d;
            alu_ctrl  <= alu_ctrl_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            mem_fetch <= mem_fetch_d;
            busy      <= busy_d;
            halted    <= halted_d;
        end
    end

endmodule

// File: tb/tb_mic_sequencer.sv
// Directed bench for mic_sequencer: small microprogram in a bench-side control
// store, expected EXEC addresses queued ahead of time and checked as they execute.
module tb_mic_sequencer;
    import mic_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [8:0]  cs_addr;
    logic [30:0] cs_data;
    logic        n_flag, z_flag;
    logic [7:0]  mbr;
    logic        mem_ready, halt;
    logic [3:0]  controlC, controlB;
    logic [7:0]  alu_ctrl;
    logic        mem_rd, mem_wr, mem_fetch, busy, halted;

    logic [30:0] rom [512];
    logic [8:0]  exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          busy_count, rd_count;

    mic_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cs_addr   (cs_addr),
        .cs_data   (cs_data),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .mbr       (mbr),
        .mem_ready (mem_ready),
        .halt      (halt),
        .controlC  (controlC),
        .controlB  (controlB),
        .alu_ctrl  (alu_ctrl),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_fetch (mem_fetch),
        .busy      (busy),
        .halted    (halted)
    );

    // Control store presents the word for cs_addr within the cycle
    assign cs_data = rom[cs_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [30:0] mk(input logic [8:0] nxt, input logic [2:0] jam,
                                       input logic [7:0] alu, input logic [3:0] cc,
                                       input logic [2:0] mem, input logic [3:0] bc);
        return {nxt, jam, alu, cc, mem, bc};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_exec(input logic [8:0] a);
        exp_q.push_back(a);
    endtask

    task automatic check_exec(input string tag);
        logic [8:0]  a;
        logic [30:0] w;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        a = exp_q.pop_front();
        w = rom[a];
        chk({tag, "_addr"},  32'(cs_addr),  32'(a));
        chk({tag, "_ccode"}, 32'(controlC), 32'(w[10:7]));
        chk({tag, "_bcode"}, 32'(controlB), 32'(w[3:0]));
        chk({tag, "_alu"},   32'(alu_ctrl), 32'(w[18:11]));
        chk({tag, "_mem"},   32'({mem_wr, mem_rd, mem_fetch}), 32'(w[6:4]));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ccode"}, 32'(controlC), 32'd15);
        chk({tag, "_bcode"}, 32'(controlB), 32'd0);
        chk({tag, "_alu"},   32'(alu_ctrl), 32'd0);
        chk({tag, "_mem"},   32'({mem_wr, mem_rd, mem_fetch}), 32'd0);
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = mk(9'h000, 3'b000, 8'h00, C_OPC, 3'b000, 4'h0);
        rom[9'h000] = mk(9'h005, 3'b000, 8'h11, C_H,   3'b000, 4'h1);
        rom[9'h005] = mk(9'h010, 3'b001, 8'h22, C_TOS, 3'b000, 4'h2);
        rom[9'h110] = mk(9'h010, 3'b001, 8'h33, 4'd9,  3'b000, 4'h3);
        rom[9'h010] = mk(9'h000, 3'b100, 8'h44, C_PC,  3'b000, C_CPP);
        rom[9'h060] = mk(9'h100, 3'b100, 8'h55, C_SP,  3'b000, C_OPC);
        rom[9'h160] = mk(9'h0FF, 3'b010, 8'h66, 4'd14, 3'b000, 4'h6);
        rom[9'h1FF] = mk(9'h020, 3'b000, 8'h77, C_MDR, 3'b010, 4'h7);
        rom[9'h020] = mk(9'h030, 3'b000, 8'h88, C_MAR, 3'b100, 4'h8);
        rom[9'h030] = mk(9'h040, 3'b000, 8'h99, C_LV,  3'b001, 4'h9);

        reset_n = 1'b0; halt = 1'b0; mem_ready = 1'b0;
        n_flag = 1'b0; z_flag = 1'b0; mbr = 8'h00;
        cyc(2);
        chk("reset_cs_addr", 32'(cs_addr), 32'h000);
        chk("reset_busy",    32'(busy),    32'd0);
        chk("reset_halted",  32'(halted),  32'd0);
        check_idle("reset");

        // Reset release: first EXEC runs address 0, then MPC = next_addr
        reset_n = 1'b1;
        expect_exec(9'h000);
        cyc(1);
        check_exec("exec0");
        z_flag = 1'b1;
        cyc(1);
        chk("next_after_0", 32'(cs_addr), 32'h005);
        check_idle("fetch");

        // JAMZ with Z set, then with Z clear
        expect_exec(9'h005);
        cyc(1);
        check_exec("jamz_set");
        cyc(1);
        chk("jamz_set_mpc", 32'(cs_addr), 32'h110);
        z_flag = 1'b0;
        expect_exec(9'h110);
        cyc(1);
        check_exec("jamz_clr");
        cyc(1);
        chk("jamz_clr_mpc", 32'(cs_addr), 32'h010);

        // JMPC with next=0x000 and next=0x100
        mbr = 8'h60;
        expect_exec(9'h010);
        cyc(1);
        check_exec("jmpc0");
        cyc(1);
        chk("jmpc0_mpc", 32'(cs_addr), 32'h060);
        expect_exec(9'h060);
        cyc(1);
        check_exec("jmpc1");
        cyc(1);
        chk("jmpc1_mpc", 32'(cs_addr), 32'h160);

        // JAMN with N set; 0x0FF | 0x100
        n_flag = 1'b1;
        expect_exec(9'h160);
        cyc(1);
        check_exec("jamn");
        cyc(1);
        chk("jamn_mpc", 32'(cs_addr), 32'h1FF);
        n_flag = 1'b0;

        // Memory read with three idle wait cycles before mem_ready
        expect_exec(9'h1FF);
        cyc(1);
        check_exec("read");
        chk("read_busy_exec", 32'(busy), 32'd0);
        rd_count = int'(mem_rd);
        busy_count = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            busy_count += int'(busy);
            rd_count += int'(mem_rd);
            check_idle("read_wait");
            if (i == 3) mem_ready = 1'b1;
        end
        chk("read_wait_mpc", 32'(cs_addr), 32'h020);
        cyc(1);
        mem_ready = 1'b0;
        chk("read_busy_done", 32'(busy), 32'd0);
        chk("read_busy_cycles", 32'(busy_count), 32'd4);
        chk("read_rd_pulses", 32'(rd_count), 32'd1);
        chk("read_then_fetch", 32'(cs_addr), 32'h020);

        // Write; halt raised during MEM_WAIT takes effect after mem_ready
        expect_exec(9'h020);
        cyc(1);
        check_exec("write");
        cyc(1);
        chk("write_busy", 32'(busy), 32'd1);
        halt = 1'b1;
        cyc(1);
        chk("write_wait_halted", 32'(halted), 32'd0);
        chk("write_wait_busy", 32'(busy), 32'd1);
        mem_ready = 1'b1;
        cyc(1);
        mem_ready = 1'b0;
        chk("halt_entered", 32'(halted), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_mpc", 32'(cs_addr), 32'h030);
        check_idle("halt");
        cyc(3);
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_hold_mpc", 32'(cs_addr), 32'h030);
        halt = 1'b0;
        cyc(1);
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_mpc", 32'(cs_addr), 32'h030);

        // Instruction fetch request, then reset in the middle of MEM_WAIT
        expect_exec(9'h030);
        cyc(1);
        check_exec("ifetch");
        cyc(1);
        chk("ifetch_busy", 32'(busy), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mpc", 32'(cs_addr), 32'h000);
        chk("midrst_halted", 32'(halted), 32'd0);
        check_idle("midrst");
        mem_ready = 1'b1;
        cyc(1);
        mem_ready = 1'b0;
        reset_n = 1'b1;
        expect_exec(9'h000);
        cyc(1);
        check_exec("restart0");
        cyc(1);
        chk("restart_mpc", 32'(cs_addr), 32'h005);
        expect_exec(9'h005);
        cyc(1);
        check_exec("restart5");
        cyc(1);
        chk("restart_jamz_clr", 32'(cs_addr), 32'h010);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
